// File: rtl/spi_flash_id_responder.sv
// SPI mode-0 slave answering JEDEC Read-ID (8'h9F) and Read-Status (8'h05).
// cs/sck/sdi are oversampled on clk12MHz; sdo updates on synchronised sck falls.
module spi_flash_id_responder #(
    parameter logic [7:0] MANUF_ID = 8'hEF,
    parameter logic [7:0] MEM_TYPE = 8'h40,
    parameter logic [7:0] CAPACITY = 8'h16,
    parameter logic [7:0] STATUS   = 8'h02
) (
    input  logic       clk12MHz,
    input  logic       rst,
    input  logic       cs,
    input  logic       sck,
    input  logic       sdi,
    output logic       sdo,
    output logic [7:0] cmd_byte,
    output logic       cmd_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CMD       = 3'd1,
        SEND_ID   = 3'd2,
        SEND_STAT = 3'd3,
        IGNORE    = 3'd4
    } state_t;

    localparam logic [7:0] CMD_READ_ID   = 8'h9F;
    localparam logic [7:0] CMD_READ_STAT = 8'h05;

    state_t     state_q, state_d;
    logic       cs_meta_q, cs_sync_q;
    logic       sck_meta_q, sck_sync_q, sck_prev_q;
    logic       sdi_meta_q, sdi_sync_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       sdo_q, sdo_d;
    logic [7:0] cmd_byte_q, cmd_byte_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       busy_q, busy_d;

    logic       sck_rise_s, sck_fall_s;
    logic [7:0] rx_next_s;

    // ID byte that follows the one at index idx; index 3 and beyond read as 8'hFF.
    function automatic logic [7:0] next_id_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = MEM_TYPE;
            2'd1:    b = CAPACITY;
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    assign sck_rise_s = sck_sync_q & ~sck_prev_q;
    assign sck_fall_s = ~sck_sync_q & sck_prev_q;
    assign rx_next_s  = {rx_shift_q[6:0], sdi_sync_q};

    // State and datapath registers, including the input synchronisers.
    always_ff @(posedge clk12MHz or negedge rst) begin
        if (!rst) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            sdi_meta_q  <= 1'b0;
            sdi_sync_q  <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            byte_idx_q  <= 2'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            sdo_q       <= 1'b1;
            cmd_byte_q  <= 8'h00;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cs_meta_q   <= cs;
            cs_sync_q   <= cs_meta_q;
            sck_meta_q  <= sck;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            sdi_meta_q  <= sdi;
            sdi_sync_q  <= sdi_meta_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_idx_q  <= byte_idx_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            sdo_q       <= sdo_d;
            cmd_byte_q  <= cmd_byte_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; a deasserted cs overrides every state and any sck edge.
    always_comb begin
        state_d = state_q;
        if (cs_sync_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = CMD;
                CMD: begin
                    if (sck_rise_s && (bit_cnt_q == 3'd7)) begin
                        if (rx_next_s == CMD_READ_ID) begin
                            state_d = SEND_ID;
                        end else if (rx_next_s == CMD_READ_STAT) begin
                            state_d = SEND_STAT;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else begin
                        state_d = CMD;
                    end
                end
                SEND_ID:   state_d = SEND_ID;
                SEND_STAT: state_d = SEND_STAT;
                IGNORE:    state_d = IGNORE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Datapath next values: command shift-in, response shift-out, flags.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        byte_idx_d  = byte_idx_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        sdo_d       = sdo_q;
        cmd_byte_d  = cmd_byte_q;
        cmd_valid_d = 1'b0;
        busy_d      = (state_d != IDLE);
        if (cs_sync_q) begin
            bit_cnt_d  = 3'd0;
            byte_idx_d = 2'd0;
            rx_shift_d = 8'h00;
            tx_shift_d = 8'h00;
            sdo_d      = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d = 3'd0;
                    sdo_d     = 1'b1;
                end
                CMD: begin
                    sdo_d = 1'b1;
                    if (sck_rise_s) begin
                        rx_shift_d = rx_next_s;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            cmd_byte_d  = rx_next_s;
                            cmd_valid_d = 1'b1;
                            byte_idx_d  = 2'd0;
                            if (rx_next_s == CMD_READ_ID) begin
                                tx_shift_d = MANUF_ID;
                            end else if (rx_next_s == CMD_READ_STAT) begin
                                tx_shift_d = STATUS;
                            end else begin
                                tx_shift_d = 8'hFF;
                            end
                        end else begin
                            cmd_valid_d = 1'b0;
                        end
                    end else begin
                        rx_shift_d = rx_shift_q;
                    end
                end
                SEND_ID, SEND_STAT: begin
                    if (sck_fall_s) begin
                        sdo_d     = tx_shift_q[7];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q != 3'd7) begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end else if (state_q == SEND_STAT) begin
                            tx_shift_d = STATUS;
                        end else begin
                            tx_shift_d = next_id_byte(byte_idx_q);
                            byte_idx_d = (byte_idx_q == 2'd3) ? 2'd3 : (byte_idx_q + 2'd1);
                        end
                    end else begin
                        sdo_d = sdo_q;
                    end
                end
                IGNORE:  sdo_d = 1'b1;
                default: sdo_d = 1'b1;
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        sdo       = sdo_q;
        cmd_byte  = cmd_byte_q;
        cmd_valid = cmd_valid_q;
        busy      = busy_q;
    end

endmodule

// File: tb/tb_spi_flash_id_responder.sv
// Directed bench: acts as an SPI mode-0 master at clk/8 and checks the responses.
module tb_spi_flash_id_responder;

    logic       clk12MHz = 1'b0;
    logic       rst;
    logic       cs;
    logic       sck;
    logic       sdi;
    logic       sdo;
    logic [7:0] cmd_byte;
    logic       cmd_valid;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;
    int vcount     = 0;

    spi_flash_id_responder dut (
        .clk12MHz (clk12MHz),
        .rst      (rst),
        .cs       (cs),
        .sck      (sck),
        .sdi      (sdi),
        .sdo      (sdo),
        .cmd_byte (cmd_byte),
        .cmd_valid(cmd_valid),
        .busy     (busy)
    );

    always #5 clk12MHz = ~clk12MHz;

    always @(negedge clk12MHz) begin
        if (cmd_valid === 1'b1) vcount++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Shift nbits of mosi out MSB first; miso collects sdo as seen at each sck rise.
    task automatic xfer_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sdi = mosi[i];
            repeat (4) @(negedge clk12MHz);
            miso = {miso[6:0], sdo};
            sck  = 1'b1;
            repeat (4) @(negedge clk12MHz);
            sck  = 1'b0;
        end
    endtask

    task automatic cs_begin();
        cs = 1'b0;
        repeat (4) @(negedge clk12MHz);
    endtask

    task automatic cs_end();
        repeat (4) @(negedge clk12MHz);
        cs = 1'b1;
        repeat (8) @(negedge clk12MHz);
    endtask

    logic [7:0] rx;
    int         v0;

    initial begin
        rst = 1'b0; cs = 1'b1; sck = 1'b0; sdi = 1'b0;
        repeat (3) @(negedge clk12MHz);
        chk("rst_sdo",      {31'd0, sdo},       32'd1);
        chk("rst_busy",     {31'd0, busy},      32'd0);
        chk("rst_valid",    {31'd0, cmd_valid}, 32'd0);
        chk("rst_cmd_byte", {24'd0, cmd_byte},  32'h00);
        rst = 1'b1;
        repeat (4) @(negedge clk12MHz);

        // Read ID
        v0 = vcount;
        cs_begin();
        chk("id_busy_start", {31'd0, busy}, 32'd1);
        xfer_bits(8'h9F, 8, rx); chk("id_cmd_phase_sdo", {24'd0, rx}, 32'hFF);
        xfer_bits(8'h00, 8, rx); chk("id_b0", {24'd0, rx}, 32'hEF);
        chk("id_busy_mid", {31'd0, busy}, 32'd1);
        xfer_bits(8'h00, 8, rx); chk("id_b1", {24'd0, rx}, 32'h40);
        xfer_bits(8'h00, 8, rx); chk("id_b2", {24'd0, rx}, 32'h16);
        chk("id_busy_end", {31'd0, busy}, 32'd1);
        cs_end();
        chk("id_busy_after", {31'd0, busy}, 32'd0);
        chk("id_sdo_idle",   {31'd0, sdo},  32'd1);
        chk("id_cmd_byte", {24'd0, cmd_byte}, 32'h9F);
        chk("id_valid_cnt", vcount - v0, 32'd1);

        // Overrun past the three ID bytes
        cs_begin();
        xfer_bits(8'h9F, 8, rx);
        xfer_bits(8'h00, 8, rx); chk("ovr_b0", {24'd0, rx}, 32'hEF);
        xfer_bits(8'h00, 8, rx); chk("ovr_b1", {24'd0, rx}, 32'h40);
        xfer_bits(8'h00, 8, rx); chk("ovr_b2", {24'd0, rx}, 32'h16);
        xfer_bits(8'h00, 8, rx); chk("ovr_b3", {24'd0, rx}, 32'hFF);
        xfer_bits(8'h00, 8, rx); chk("ovr_b4", {24'd0, rx}, 32'hFF);
        cs_end();

        // Status read repeats STATUS
        cs_begin();
        xfer_bits(8'h05, 8, rx);
        xfer_bits(8'h00, 8, rx); chk("st_b0", {24'd0, rx}, 32'h02);
        xfer_bits(8'h00, 8, rx); chk("st_b1", {24'd0, rx}, 32'h02);
        xfer_bits(8'h00, 8, rx); chk("st_b2", {24'd0, rx}, 32'h02);
        cs_end();
        chk("st_cmd_byte", {24'd0, cmd_byte}, 32'h05);

        // Unknown command leaves sdo high, then a fresh Read ID works
        cs_begin();
        xfer_bits(8'h03, 8, rx);
        xfer_bits(8'hA5, 8, rx); chk("unk_b0", {24'd0, rx}, 32'hFF);
        xfer_bits(8'h5A, 8, rx); chk("unk_b1", {24'd0, rx}, 32'hFF);
        cs_end();
        chk("unk_cmd_byte", {24'd0, cmd_byte}, 32'h03);
        cs_begin();
        xfer_bits(8'h9F, 8, rx);
        xfer_bits(8'h00, 8, rx); chk("unk_then_id", {24'd0, rx}, 32'hEF);
        cs_end();

        // Abort after 5 command bits, then a full Read ID
        v0 = vcount;
        cs_begin();
        xfer_bits(8'h9F, 5, rx);
        cs_end();
        chk("abort_no_valid", vcount - v0, 32'd0);
        chk("abort_cmd_byte", {24'd0, cmd_byte}, 32'h9F);
        v0 = vcount;
        cs_begin();
        xfer_bits(8'h9F, 8, rx);
        xfer_bits(8'h00, 8, rx); chk("abort_id_b0", {24'd0, rx}, 32'hEF);
        xfer_bits(8'h00, 8, rx); chk("abort_id_b1", {24'd0, rx}, 32'h40);
        xfer_bits(8'h00, 8, rx); chk("abort_id_b2", {24'd0, rx}, 32'h16);
        cs_end();
        chk("abort_valid_cnt", vcount - v0, 32'd1);

        // Asynchronous reset in the middle of an ID transfer
        cs_begin();
        xfer_bits(8'h9F, 8, rx);
        xfer_bits(8'h00, 3, rx);
        @(negedge clk12MHz);
        #2 rst = 1'b0;
        #1;
        chk("arst_sdo",      {31'd0, sdo},       32'd1);
        chk("arst_busy",     {31'd0, busy},      32'd0);
        chk("arst_valid",    {31'd0, cmd_valid}, 32'd0);
        chk("arst_cmd_byte", {24'd0, cmd_byte},  32'h00);
        cs = 1'b1; sck = 1'b0;
        repeat (3) @(negedge clk12MHz);
        rst = 1'b1;
        repeat (4) @(negedge clk12MHz);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_flash_id_responder.md
Name: spi_flash_id_responder

Overview:
SPI-mode-0 slave that models the flash-side end of the JEDEC Read-ID exchange. It lets the ID-reading master be exercised in simulation and on a second FPGA pin set without a real flash part. The block oversamples cs/sck/sdi on clk12MHz, decodes the first byte of each transaction, and shifts back either the 3-byte JEDEC ID or a status byte on sdo.

Parameters:
MANUF_ID, 8'hEF, byte 0 returned after command 8'h9F
MEM_TYPE, 8'h40, byte 1 returned after 8'h9F
CAPACITY, 8'h16, byte 2 returned after 8'h9F
STATUS, 8'h02, byte returned repeatedly after command 8'h05

Ports:
clk12MHz  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
cs  in  1  chip select from master, active low
sck  in  1  SPI clock from master; idle low (mode 0)
sdi  in  1  master-out data, sampled on sck rising edge
sdo  out  1  slave-out data, changed on sck falling edge
cmd_byte  out  8  last command byte received
cmd_valid  out  1  one-clk pulse when cmd_byte is updated
busy  out  1  high while cs is low (synchronised)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, sdo=1, cmd_byte=8'h00, cmd_valid=0, busy=0, bit counter=0, byte index=0, shift registers=0.
- cs, sck and sdi each pass through a 2-FF synchroniser. Edges are detected on the synchronised sck: rise = cur&~prev, fall = ~cur&prev. sck high and low phases are each at least 2 clk12MHz periods; faster sck is unsupported.
- Synchronised cs high in any state forces IDLE on the next clk and clears the bit counter and byte index. sdo=1 and busy=0. This is how a transaction aborted mid-byte is handled.
- States:
  - IDLE: wait for synchronised cs low, then go to CMD with busy=1.
  - CMD: on each sck rise, shift sdi into rx_shift (MSB first) and increment the 3-bit counter. On the 8th rise:
    - cmd_byte <= received byte; cmd_valid pulses 1 clk.
    - 8'h9F -> SEND_ID, byte index 0, tx_shift <= MANUF_ID.
    - 8'h05 -> SEND_STAT, tx_shift <= STATUS.
    - any other byte -> IGNORE.
  - SEND_ID: on each sck fall, sdo <= tx_shift[7] and tx_shift shifts left. The first fall after the 8th command rise outputs MANUF_ID[7], so the master samples it on the next rise. After 8 falls, load the next byte: MEM_TYPE, then CAPACITY, then 8'hFF for every later byte (index saturates at 3).
  - SEND_STAT: same shifting as SEND_ID, but STATUS is reloaded after every 8 falls, indefinitely.
  - IGNORE: sdo=1 until cs goes high.
- sdo holds its value between falls. sdo=1 in IDLE, in CMD, and in IGNORE.
- Simultaneous events:
  - cs rising in the same clk as an sck edge: cs wins and the edge is discarded.
  - sck fall with no preceding rise after cs fell: ignored in CMD.
- Latency: sdo changes 3 clk12MHz cycles after the raw sck falling edge (2 synchroniser + 1 register). cmd_valid asserts 3 cycles after the raw 8th rise.
- No SPI-side state persists across transactions except cmd_byte.

Test Plan:
- Reset: rst=0 mid-transaction -> sdo=1, busy=0, cmd_valid=0, cmd_byte=8'h00 immediately (asynchronous).
- Read ID: cs low, send 8'h9F, clock 24 more bits with sck at clk/8 -> master samples EF 40 16; one cmd_valid pulse with cmd_byte=8'h9F; busy=1 throughout.
- Overrun: after 8'h9F, clock 40 bits -> EF 40 16 FF FF.
- Status: send 8'h05, clock 24 bits -> 02 02 02.
- Unknown command 8'h03, clock 16 bits -> sdo stays 1; cmd_byte=8'h03. Then cs high, new transaction with 8'h9F -> EF returned, proving state was cleared.
- Abort: raise cs after 5 command bits, then a full 8'h9F transaction -> no cmd_valid for the partial byte; the full transaction returns EF 40 16 correctly.
